game_irq_arbiter: RTL and testbench
===================================

// Module: game_irq_arbiter
// PURPOSE
//  Sequences game-event interrupts (coin hit, barrier hit) from the gfx/state_machine datapath to the host.
//  Edge-detects hit levels, latches pending, masks, arbitrates (barrier > coin) and runs a req/ack handshake.
//  Rate-limits by video frame and counts events. Sits between gfx/FSM outputs and coin_intr/barrier_intr pins.
// PARAMETERS
//  CNT_W           8      width of saturating event counters
//  HOLDOFF_FRAMES  2      frame pulses to wait after an ack/timeout before next grant (0 = none)
//  TIMEOUT_FRAMES  60     frame pulses in ASSERT without ack before abandon (0 = never)
//  GAME_OVER_STATE 8'd10  FSM state code in which barrier events are ignored
// PORTS
//  i_pix_clk          in   1      pixel clock; sole clock
//  i_rst_n            in   1      asynchronous, active-low reset
//  i_frame            in   1      1-cycle frame-start pulse (display_timings o_frame)
//  i_state            in   8      current game FSM state
//  i_coin_hit         in   1      coin collision level (multi-cycle)
//  i_barrier_hit      in   1      barrier collision level (multi-cycle)
//  i_mask             in   2      [0]=mask coin, [1]=mask barrier; 1 = no new pending
//  i_ack              in   1      host ack; honoured only in ASSERT
//  o_coin_intr        out  1      interrupt line, coin granted
//  o_barrier_intr     out  1      interrupt line, barrier granted
//  o_pending          out  2      pending bits {barrier, coin}
//  o_coin_count       out  CNT_W  accepted coin events, saturating
//  o_barrier_count    out  CNT_W  accepted barrier events, saturating
//  o_overflow         out  1      sticky: edge arrived while same source already pending
//  o_timeout          out  1      sticky: ASSERT abandoned by timeout
// BEHAVIOUR
//  Reset (async, i_rst_n=0): all outputs 0, state IDLE, edge regs 0, frame counter 0.
//  Edge: rise = hit & ~hit_q (hit_q registered). Barrier rise ignored when i_state==GAME_OVER_STATE.
//  Accepted edge (unmasked): pending[src]<=1, count[src]+=1 (stick at all-ones); if pending[src] already 1 -> o_overflow<=1.
//  Masked edge: no pending, no count, no overflow. Masking does not clear existing pending.
//  FSM IDLE -> GRANT when |o_pending; GRANT latches id = barrier if pending[1] else coin (1 cycle).
//  ASSERT: o_<id>_intr=1 (registered, first high cycle after GRANT); frame counter cleared on entry.
//   i_ack=1 -> pending[id]<=0, intr<=0 next cycle, -> HOLDOFF.
//   TIMEOUT_FRAMES frames counted with no ack -> o_timeout<=1, pending kept, -> HOLDOFF.
//  HOLDOFF: count i_frame pulses; at HOLDOFF_FRAMES -> IDLE (HOLDOFF_FRAMES=0: single cycle).
//  i_ack outside ASSERT ignored. Exactly one intr line high at a time; never both.
//  Same-cycle ack and new edge of granted source: pending stays 1, count increments, no overflow.
//  Edge of other source during ASSERT: sets its pending; served after HOLDOFF.
//  Grant id fixed for whole ASSERT even if higher-priority pending arrives.
//  Latency: rise at input -> intr high 3 cycles later from IDLE (edge reg, pending, GRANT).
//  Reset mid-ASSERT: intr drops immediately (async), all state lost.
// STRUCTURE
//  Shared pkg/header game_defs: state codes (GAME_OVER_STATE), IRQ_ID_COIN=2'd1, IRQ_ID_BARRIER=2'd2, FSM encodings.
//  One sub-module: irq_src_latch (edge detect + pending + saturating counter + overflow), instanced per source.
//  Arbiter FSM + frame counter in top.
// TESTING
//  Coin rise, no mask -> pending=01, o_coin_intr high 3 clks later; ack -> intr low next clk, coin_count=1.
//  Coin+barrier rise same cycle -> barrier intr first; ack; 2 frames holdoff; then coin intr.
//  i_state=8'd10, barrier rise -> no pending, barrier_count=0; coin still served.
//  Coin rise twice before ack -> o_overflow=1, coin_count=2, single intr.
//  TIMEOUT_FRAMES=3, no ack -> after 3 frame pulses o_timeout=1, intr low, pending kept, re-asserted after holdoff.
//  255 accepted coin events at CNT_W=8, then one more -> count stays 8'hFF; i_rst_n low mid-ASSERT -> all zero.

Source files
------------

// File: rtl/game_defs_pkg.sv
// rtl/game_defs_pkg.sv - shared codes and FSM encoding for the game interrupt arbiter
package game_defs;

  localparam logic [7:0] GAME_OVER_STATE_DEF = 8'd10;
  localparam logic [1:0] IRQ_ID_COIN         = 2'd1;
  localparam logic [1:0] IRQ_ID_BARRIER      = 2'd2;
  localparam int         FRAME_CNT_W         = 8;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_ASSERT  = 2'd2,
    ARB_HOLDOFF = 2'd3
  } arb_state_e;

  // Counter value seen on the cycle whose frame pulse completes n frames.
  function automatic logic [FRAME_CNT_W-1:0] frame_target(input int unsigned n);
    return FRAME_CNT_W'(n - 32'd1);
  endfunction

endpackage

// File: rtl/game_irq_arbiter_irq_src_latch.sv
// rtl/game_irq_arbiter_irq_src_latch.sv - per-source edge detect, pending latch, saturating count, overflow
module irq_src_latch #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_hit,
  input  logic             i_ignore,
  input  logic             i_mask,
  input  logic             i_clear,
  output logic             o_pending,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow
);

  logic             hit_q;
  logic             pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;

  assign accept = i_hit & ~hit_q & ~i_ignore & ~i_mask;

  always_comb begin
    pending_d  = pending_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (accept) begin
      pending_d = 1'b1;
      if (count_q != '1) count_d = count_q + CNT_W'(1);
      // an ack in the same cycle retires the old event, so the new one is not lost
      if (pending_q && !i_clear) overflow_d = 1'b1;
    end else if (i_clear) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_q      <= 1'b0;
      pending_q  <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      hit_q      <= i_hit;
      pending_q  <= pending_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_pending  = pending_q;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;

endmodule

// File: rtl/game_irq_arbiter.sv
// rtl/game_irq_arbiter.sv - coin/barrier interrupt arbiter with req/ack handshake and frame rate limit
module game_irq_arbiter
  import game_defs::*;
#(
  parameter int         CNT_W           = 8,
  parameter int         HOLDOFF_FRAMES  = 2,
  parameter int         TIMEOUT_FRAMES  = 60,
  parameter logic [7:0] GAME_OVER_STATE = GAME_OVER_STATE_DEF
) (
  input  logic             i_pix_clk,
  input  logic             i_rst_n,
  input  logic             i_frame,
  input  logic [7:0]       i_state,
  input  logic             i_coin_hit,
  input  logic             i_barrier_hit,
  input  logic [1:0]       i_mask,
  input  logic             i_ack,
  output logic             o_coin_intr,
  output logic             o_barrier_intr,
  output logic [1:0]       o_pending,
  output logic [CNT_W-1:0] o_coin_count,
  output logic [CNT_W-1:0] o_barrier_count,
  output logic             o_overflow,
  output logic             o_timeout
);

  arb_state_e             state_q, state_d;
  logic [1:0]             id_q, id_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   ovf_coin, ovf_barrier;
  logic                   ack_ok, timeout_hit, holdoff_done;

  assign ack_ok       = (state_q == ARB_ASSERT) && i_ack;
  assign timeout_hit  = (TIMEOUT_FRAMES != 0) && i_frame &&
                        (frame_cnt_q == frame_target(TIMEOUT_FRAMES));
  assign holdoff_done = (HOLDOFF_FRAMES == 0) ||
                        (i_frame && (frame_cnt_q == frame_target(HOLDOFF_FRAMES)));

  irq_src_latch #(.CNT_W(CNT_W)) u_coin (
    .i_clk      (i_pix_clk),
    .i_rst_n    (i_rst_n),
    .i_hit      (i_coin_hit),
    .i_ignore   (1'b0),
    .i_mask     (i_mask[0]),
    .i_clear    (ack_ok && (id_q == IRQ_ID_COIN)),
    .o_pending  (o_pending[0]),
    .o_count    (o_coin_count),
    .o_overflow (ovf_coin)
  );

  irq_src_latch #(.CNT_W(CNT_W)) u_barrier (
    .i_clk      (i_pix_clk),
    .i_rst_n    (i_rst_n),
    .i_hit      (i_barrier_hit),
    .i_ignore   (i_state == GAME_OVER_STATE),
    .i_mask     (i_mask[1]),
    .i_clear    (ack_ok && (id_q == IRQ_ID_BARRIER)),
    .o_pending  (o_pending[1]),
    .o_count    (o_barrier_count),
    .o_overflow (ovf_barrier)
  );

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ARB_IDLE;
      id_q        <= 2'd0;
      frame_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      frame_cnt_q <= frame_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ARB_IDLE:    if (|o_pending) state_d = ARB_GRANT;
      ARB_GRANT: begin
        id_d    = o_pending[1] ? IRQ_ID_BARRIER : IRQ_ID_COIN;
        state_d = ARB_ASSERT;
      end
      ARB_ASSERT: begin
        if (i_ack) begin
          state_d = ARB_HOLDOFF;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          state_d   = ARB_HOLDOFF;
        end
      end
      ARB_HOLDOFF: if (holdoff_done) state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
    // every state change restarts the frame count for the state being entered
    frame_cnt_d = (state_d != state_q) ? '0 : frame_cnt_q + FRAME_CNT_W'(i_frame);
  end

  always_comb begin
    o_coin_intr    = (state_q == ARB_ASSERT) && (id_q == IRQ_ID_COIN);
    o_barrier_intr = (state_q == ARB_ASSERT) && (id_q == IRQ_ID_BARRIER);
    o_overflow     = ovf_coin | ovf_barrier;
    o_timeout      = timeout_q;
  end

endmodule

// File: tb/tb_game_irq_arbiter.sv
// tb/tb_game_irq_arbiter.sv - scoreboard bench for game_irq_arbiter
module tb_game_irq_arbiter;

  localparam logic [1:0] ID_COIN = 2'd1;
  localparam logic [1:0] ID_BAR  = 2'd2;

  logic       clk;
  logic       i_rst_n;
  logic       i_frame;
  logic [7:0] i_state;
  logic       i_coin_hit, i_barrier_hit;
  logic [1:0] i_mask;
  logic       i_ack;
  logic       o_coin_intr, o_barrier_intr;
  logic [1:0] o_pending;
  logic [7:0] o_coin_count, o_barrier_count;
  logic       o_overflow, o_timeout;

  typedef struct {
    logic [1:0] id;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [1:0] mon_prev = 2'b00;
  logic [1:0] mon_cur;

  game_irq_arbiter #(
    .CNT_W          (8),
    .HOLDOFF_FRAMES (2),
    .TIMEOUT_FRAMES (3),
    .GAME_OVER_STATE(8'd10)
  ) dut (
    .i_pix_clk      (clk),
    .i_rst_n        (i_rst_n),
    .i_frame        (i_frame),
    .i_state        (i_state),
    .i_coin_hit     (i_coin_hit),
    .i_barrier_hit  (i_barrier_hit),
    .i_mask         (i_mask),
    .i_ack          (i_ack),
    .o_coin_intr    (o_coin_intr),
    .o_barrier_intr (o_barrier_intr),
    .o_pending      (o_pending),
    .o_coin_count   (o_coin_count),
    .o_barrier_count(o_barrier_count),
    .o_overflow     (o_overflow),
    .o_timeout      (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every new interrupt assertion is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    mon_cur = {o_barrier_intr, o_coin_intr};
    if (mon_cur != 2'b00 && mon_prev == 2'b00) begin
      check("intr_one_hot", int'(mon_cur == 2'b01 || mon_cur == 2'b10), 1);
      if (exp_q.size() == 0) begin
        check("intr_unexpected", int'(mon_cur), 0);
      end else begin
        e = exp_q.pop_front();
        check("intr_id", int'(mon_cur), int'(e.id));
        check("intr_cycle", cyc, e.cyc);
      end
    end
    mon_prev = mon_cur;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    i_frame = 1'b1;
    tick(1);
    i_frame = 1'b0;
  endtask

  task automatic ack();
    i_ack = 1'b1;
    tick(1);
    i_ack = 1'b0;
  endtask

  task automatic expect_intr(input logic [1:0] id, input int delay);
    exp_q.push_back('{id: id, cyc: cyc + delay});
  endtask

  task automatic do_reset();
    i_coin_hit = 0; i_barrier_hit = 0; i_ack = 0; i_frame = 0; i_mask = 0; i_state = 0;
    i_rst_n = 0;
    tick(2);
    i_rst_n = 1;
    tick(1);
  endtask

  initial begin
    i_rst_n = 1; i_coin_hit = 0; i_barrier_hit = 0; i_ack = 0; i_frame = 0; i_mask = 0; i_state = 0;
    #2 i_rst_n = 0;
    tick(2);
    check("rst_pending", o_pending, 0);
    check("rst_intr", {o_barrier_intr, o_coin_intr}, 0);
    check("rst_counts", {o_barrier_count, o_coin_count}, 0);
    check("rst_flags", {o_overflow, o_timeout}, 0);
    i_rst_n = 1;
    tick(1);

    // single coin event, 3-cycle latency, ack drops intr next cycle
    expect_intr(ID_COIN, 3);
    i_coin_hit = 1; tick(1);
    check("t1_pending", o_pending, 2'b01);
    i_coin_hit = 0; tick(2);
    check("t1_intr", o_coin_intr, 1);
    ack();
    check("t1_intr_drop", o_coin_intr, 0);
    check("t1_pending_clr", o_pending, 0);
    check("t1_coin_count", o_coin_count, 1);
    frame(); frame(); tick(2);

    // simultaneous events: barrier first, coin after two-frame holdoff
    do_reset();
    expect_intr(ID_BAR, 3);
    i_coin_hit = 1; i_barrier_hit = 1; tick(1);
    check("t2_pending", o_pending, 2'b11);
    i_coin_hit = 0; i_barrier_hit = 0; tick(2);
    check("t2_bar_intr", {o_barrier_intr, o_coin_intr}, 2'b10);
    ack();
    check("t2_pending_after_ack", o_pending, 2'b01);
    check("t2_bar_count", o_barrier_count, 1);
    frame(); frame();
    expect_intr(ID_COIN, 2);
    tick(2);
    check("t2_coin_intr", {o_barrier_intr, o_coin_intr}, 2'b01);
    ack();
    check("t2_all_clear", o_pending, 0);
    frame(); frame(); tick(2);

    // game-over state drops barrier events, coin still served
    do_reset();
    i_state = 8'd10;
    expect_intr(ID_COIN, 3);
    i_coin_hit = 1; i_barrier_hit = 1; tick(1);
    check("t3_pending", o_pending, 2'b01);
    i_coin_hit = 0; i_barrier_hit = 0; tick(2);
    check("t3_bar_count", o_barrier_count, 0);
    ack();
    i_state = 8'd0;
    frame(); frame(); tick(2);

    // masked edges leave no trace; masking keeps existing pending
    do_reset();
    i_mask = 2'b11;
    i_coin_hit = 1; i_barrier_hit = 1; tick(1);
    i_coin_hit = 0; i_barrier_hit = 0; tick(3);
    check("t3m_pending", o_pending, 0);
    check("t3m_counts", {o_barrier_count, o_coin_count}, 0);
    i_mask = 2'b00;

    // second coin edge before ack -> overflow, one interrupt
    do_reset();
    expect_intr(ID_COIN, 3);
    i_coin_hit = 1; tick(1);
    i_coin_hit = 0; tick(1);
    check("t4_no_ovf_yet", o_overflow, 0);
    i_coin_hit = 1; tick(1);
    i_coin_hit = 0;
    check("t4_overflow", o_overflow, 1);
    check("t4_coin_count", o_coin_count, 2);
    ack();
    check("t4_pending_clr", o_pending, 0);
    frame(); frame(); tick(4);

    // ack coinciding with a new edge of the granted source
    do_reset();
    expect_intr(ID_COIN, 3);
    i_coin_hit = 1; tick(1);
    i_coin_hit = 0; tick(2);
    i_coin_hit = 1; i_ack = 1; tick(1);
    i_coin_hit = 0; i_ack = 0;
    check("t4b_pending", o_pending, 2'b01);
    check("t4b_count", o_coin_count, 2);
    check("t4b_no_ovf", o_overflow, 0);
    check("t4b_intr_low", o_coin_intr, 0);
    frame(); frame();
    expect_intr(ID_COIN, 2);
    tick(2);
    ack();
    check("t4b_pending_clr", o_pending, 0);
    frame(); frame(); tick(2);

    // timeout after three frames, re-asserted after holdoff
    do_reset();
    expect_intr(ID_COIN, 3);
    i_coin_hit = 1; tick(1);
    i_coin_hit = 0; tick(2);
    frame(); frame();
    check("t5_no_timeout_yet", o_timeout, 0);
    frame();
    check("t5_timeout", o_timeout, 1);
    check("t5_intr_low", o_coin_intr, 0);
    check("t5_pending_kept", o_pending, 2'b01);
    frame(); frame();
    expect_intr(ID_COIN, 2);
    tick(2);
    check("t5_reassert", o_coin_intr, 1);
    ack();
    check("t5_timeout_sticky", o_timeout, 1);
    frame(); frame(); tick(2);

    // counter saturation, then asynchronous reset mid-ASSERT
    do_reset();
    expect_intr(ID_COIN, 3);
    for (int i = 0; i < 255; i++) begin
      i_coin_hit = 1; tick(1);
      i_coin_hit = 0; tick(1);
    end
    check("t6_count_255", o_coin_count, 8'hFF);
    i_coin_hit = 1; tick(1);
    i_coin_hit = 0; tick(1);
    check("t6_count_sat", o_coin_count, 8'hFF);
    check("t6_intr_high", o_coin_intr, 1);
    i_rst_n = 0;
    #1;
    check("t6_rst_intr", {o_barrier_intr, o_coin_intr}, 0);
    check("t6_rst_count", o_coin_count, 0);
    check("t6_rst_state", {o_pending, o_overflow, o_timeout}, 0);
    tick(1);
    i_rst_n = 1;
    tick(3);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
